// File: rtl/uart_rx_buffer_pkg.sv
// rtl/uart_rx_buffer_pkg.sv - shared receiver state encoding and 8N1 frame constants
package uart_rx_buffer_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - register-array byte FIFO with wrapping pointers and a separate occupancy count
module rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            din,
    input  logic                  pop,
    output logic [7:0]            dout,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 UART receiver feeding a byte FIFO; RX_OVERRUN_EN adds a sticky overrun flag
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic                  pop,
    output logic [7:0]            rx_data,
    output logic                  rx_wait,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  frame_error
`ifdef RX_OVERRUN_EN
    ,
    output logic                  overrun
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(CLKS_PER_BIT);
    localparam int BW    = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q, prev_q;
    logic                 rxd_s;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_error_q, frame_error_d;
    logic                 push;
    logic [CW-1:0]        fifo_count;

    assign rxd_s = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
        end else begin
            sync1_q       <= rxd;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q + TW'(1);
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        frame_error_d = 1'b0;
        push          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                // Edge-triggered start: after a bad stop bit the line must return high first.
                if (prev_q && !rxd_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_q == T_HALF) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                    if (rxd_s) begin
                        push = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    rx_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (shift_q),
        .pop   (pop),
        .dout  (rx_data),
        .count (fifo_count)
    );

    assign count       = fifo_count;
    assign rx_wait     = (fifo_count == '0);
    assign frame_error = frame_error_q;

`ifdef RX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (push && (fifo_count == CW'(DEPTH)) && !pop) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer with CLKS_PER_BIT=4, DEPTH_LOG2=2
module tb_uart_rx_buffer;
    import uart_rx_buffer_pkg::*;

    localparam int CPB   = 4;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        pop = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_wait;
    logic [DL:0] count;
    logic        frame_error;
`ifdef RX_OVERRUN_EN
    logic        overrun;
`endif

    int         n_checks = 0;
    int         n_fail = 0;
    int         fe_cycles = 0;
    int         fe_base;
    logic [7:0] exp_q[$];

    uart_rx_buffer #(
        .CLKS_PER_BIT(CPB),
        .DEPTH_LOG2  (DL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .pop        (pop),
        .rx_data    (rx_data),
        .rx_wait    (rx_wait),
        .count      (count),
`ifdef RX_OVERRUN_EN
        .overrun    (overrun),
`endif
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_error) fe_cycles++;
        if (!reset && pop && !rx_wait) begin
            if (exp_q.size() == 0) check("sb_extra_pop", 32'(exp_q.size()), 32'd1);
            else check("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line_bit(input logic v);
        rxd = v;
        idle(CPB);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        idle(1);
        pop = 1'b0;
    endtask

    // Returns on the stop-sample cycle, or one cycle later when pop_end pops during that cycle.
    task automatic send(input logic [7:0] b, input logic stop_ok, input logic pop_end);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop_ok);
        if (stop_ok) begin
            if (!(exp_q.size() == DEPTH && !pop_end)) exp_q.push_back(b);
        end
        if (pop_end) do_pop();
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        check("reset_rx_wait", 32'(rx_wait), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
`ifdef RX_OVERRUN_EN
        check("reset_overrun", 32'(overrun), 32'd0);
`endif
        idle(4);

        send(8'hA5, 1'b1, 1'b0);
        check("a5_wait_at_sample", 32'(rx_wait), 32'd1);
        idle(1);
        check("a5_wait_after", 32'(rx_wait), 32'd0);
        check("a5_head", 32'(rx_data), 32'hA5);
        check("a5_count", 32'(count), 32'd1);
        do_pop();
        check("a5_pop_wait", 32'(rx_wait), 32'd1);
        check("a5_pop_count", 32'(count), 32'd0);

        idle(2);
        rxd = 1'b0;
        idle(1);
        rxd = 1'b1;
        idle(10);
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("glitch_fe", 32'(fe_cycles), 32'd0);

        fe_base = fe_cycles;
        send(8'h3C, 1'b0, 1'b0);
        rxd = 1'b1;
        idle(6);
        check("fe_pulse_cycles", 32'(fe_cycles - fe_base), 32'd1);
        check("fe_count", 32'(count), 32'd0);

        for (int k = 1; k <= 5; k++) begin
            send(8'(k), 1'b1, 1'b0);
            idle(2);
        end
        check("ovf_count", 32'(count), 32'd4);
`ifdef RX_OVERRUN_EN
        check("ovf_overrun", 32'(overrun), 32'd1);
`endif
        for (int k = 0; k < 4; k++) do_pop();
        check("ovf_drain_count", 32'(count), 32'd0);

        for (int k = 1; k <= 4; k++) begin
            send(8'(k), 1'b1, 1'b0);
            idle(2);
        end
        send(8'h06, 1'b1, 1'b1);
        idle(1);
        check("fullpop_count", 32'(count), 32'd4);
        for (int k = 0; k < 4; k++) do_pop();
        check("fullpop_drain", 32'(count), 32'd0);

        idle(2);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        reset = 1'b1;
        exp_q.delete();
        rxd = 1'b1;
        idle(2);
        reset = 1'b0;
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("midrst_wait", 32'(rx_wait), 32'd1);
`ifdef RX_OVERRUN_EN
        check("midrst_overrun", 32'(overrun), 32'd0);
`endif
        idle(4);
        send(8'h5A, 1'b1, 1'b0);
        idle(2);
        check("midrst_count", 32'(count), 32'd1);
        do_pop();
        check("midrst_drain", 32'(count), 32'd0);

        idle(2);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 4.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of the FIFO depth (16 entries).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port rxd, input, 1, meaning asynchronous serial line; idles high; 8N1 framing.
REQ-006 SHALL have port pop, input, 1, meaning the CPU retires one INPUTB this cycle and consumes the head byte.
REQ-007 SHALL have port rx_data, output, 8, meaning the FIFO head byte; valid only while rx_wait=0.
REQ-008 SHALL have port rx_wait, output, 1, meaning the FIFO is empty; the decoder freezes INPUTB while it is 1.
REQ-009 SHALL have port count, output, DEPTH_LOG2+1, meaning the number of bytes held.
REQ-010 SHALL have port frame_error, output, 1, meaning a one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1, meaning sticky byte-dropped flag; present only under RX_OVERRUN_EN.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer that resets to 1; all sampling uses the synchronized value.
REQ-013 SHALL implement the receiver FSM states IDLE, START, DATA and STOP.
REQ-014 In IDLE, a synchronized high-to-low transition SHALL move the FSM to START and clear the bit timer.
REQ-015 START SHALL sample at CLKS_PER_BIT/2 cycles: if the line is low, go to DATA; if high, treat it as a glitch and return to IDLE with no push and no error.
REQ-016 DATA SHALL sample 8 bits LSB first, one sample every CLKS_PER_BIT cycles after the start midpoint, then go to STOP.
REQ-017 STOP SHALL sample after a further CLKS_PER_BIT cycles: a 1 requests a push of the assembled byte; a 0 pulses frame_error for one cycle, discards the byte, and returns to IDLE, which rearms only after the line is seen high.
REQ-018 After a push, rx_wait SHALL fall and rx_data SHALL show the byte on the cycle after the stop-bit sample.
REQ-019 The FIFO SHALL be a register array with DEPTH_LOG2-bit read and write pointers that wrap modulo 2^DEPTH_LOG2; count SHALL be tracked separately so that empty (count=0) and full (count=depth) are unambiguous.
REQ-020 rx_data SHALL be a combinational read of mem[rd_ptr]; rx_wait SHALL equal (count==0), combinational from registered count.
REQ-021 pop while empty SHALL be ignored: no pointer or count change.
REQ-022 Push while full without pop SHALL drop the new byte and leave FIFO contents unchanged.
REQ-023 Push and pop in the same cycle SHALL both take effect with count unchanged, including when the FIFO is full.
REQ-024 The receiver FSM SHALL never stall on FIFO state.

Reset
REQ-025 On reset SHALL set FSM=IDLE, pointers=0, count=0, rx_wait=1, frame_error=0, overrun=0, and synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame; the next falling edge after reset releases starts a new frame.
REQ-027 FIFO memory contents SHALL NOT require reset.

Configuration
REQ-028 With RX_OVERRUN_EN defined, overrun SHALL set on any dropped push and clear only on reset.
REQ-029 Without RX_OVERRUN_EN defined, the overrun port and its logic SHALL be absent; drops remain silent.

Structure
REQ-030 The FSM state encoding and the UART frame constants (8 data bits, 1 stop bit) SHALL live in a shared package/header next to opcode.h.
REQ-031 The FIFO SHALL be a sub-module named rx_fifo with ports push, din, pop, dout, count; uart_rx_buffer instantiates it.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=2)
REQ-032 Send 0xA5 with a valid stop bit -> rx_wait falls 1 cycle after the stop sample; rx_data=0xA5; pop -> rx_wait=1, count=0.
REQ-033 Low glitch of 1 cycle on idle rxd -> no push; FSM back in IDLE; frame_error stays 0.
REQ-034 Send 0x3C with stop bit=0 -> frame_error pulses exactly 1 cycle; count stays 0.
REQ-035 Send 5 bytes 0x01..0x05 with no pop -> count=4; head reads 0x01..0x04 on successive pops; overrun=1 (EN build only).
REQ-036 FIFO full, pop asserted on the push cycle of 0x06 -> count stays 4; the last byte read out is 0x06.
REQ-037 Reset asserted mid-DATA, then 0x5A sent -> only 0x5A is received; count=1.
